// File: rtl/pdp8_eae_pkg.sv
// Shared definitions for the EAE shift/normalise engine: op encodings,
// FSM states and the shift-length limit of the {L,AC,MQ} triple.
package pdp8_eae_pkg;

  typedef enum logic [1:0] {
    EAE_SHL = 2'b00,
    EAE_ASR = 2'b01,
    EAE_LSR = 2'b10,
    EAE_NMI = 2'b11
  } eae_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } eae_state_e;

  // Longest meaningful shift: every bit of {L,AC,MQ} has left the triple.
  function automatic int max_shift(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/eae_shift_step.sv
// Combinational single-bit step of the {L,AC,MQ} triple. Vectors are stored
// [W-1:0], so the architectural bit 0 (MSB) is index W-1 here.
module eae_shift_step
  import pdp8_eae_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [1:0]   op,
  input  logic         l_i,
  input  logic [W-1:0] ac_i,
  input  logic [W-1:0] mq_i,
  output logic         l_o,
  output logic [W-1:0] ac_o,
  output logic [W-1:0] mq_o,
  output logic         norm_o,
  output logic         norm_next_o
);

  // One-bit shift of the triple according to op.
  always_comb begin
    l_o  = l_i;
    ac_o = ac_i;
    mq_o = mq_i;
    case (op)
      EAE_SHL, EAE_NMI: {l_o, ac_o, mq_o} = {ac_i, mq_i, 1'b0};
      EAE_ASR: begin
        {ac_o, mq_o} = {ac_i[W-1], ac_i, mq_i[W-1:1]};
        l_o          = ac_i[W-1];
      end
      EAE_LSR: begin
        {ac_o, mq_o} = {1'b0, ac_i, mq_i[W-1:1]};
        l_o          = 1'b0;
      end
      default: ;
    endcase
  end

  // Normalised: top two AC bits differ, or nothing left below them to shift up.
  // norm_o judges the incoming value, norm_next_o the stepped value.
  assign norm_o      = (ac_i[W-1] != ac_i[W-2]) || ({ac_i[W-3:0], mq_i} == '0);
  assign norm_next_o = (ac_o[W-1] != ac_o[W-2]) || ({ac_o[W-3:0], mq_o} == '0);

endmodule

// File: rtl/eae_shift_engine.sv
// Iterative SHL/ASR/LSR/NMI engine for the {L,AC,MQ} triple, one bit per cycle.
// Handshake: start is sampled only in IDLE; busy is high while shifting; done
// is a one-cycle pulse after which the result outputs hold until the next
// accepted start. abort returns to IDLE without done and beats start.
module eae_shift_engine
  import pdp8_eae_pkg::*;
#(
  parameter int W  = 12,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    op,
  input  logic          mode_b,
  input  logic [CW-1:0] count,
  input  logic          l_in,
  input  logic [W-1:0]  ac_in,
  input  logic [W-1:0]  mq_in,
  output logic          busy,
  output logic          done,
  output logic          l_out,
  output logic [W-1:0]  ac_out,
  output logic [W-1:0]  mq_out,
  output logic [CW-1:0] sc_out
);

  localparam logic [CW:0] MAX_K = (CW + 1)'(max_shift(W));

  eae_state_e    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          l_q, l_d;
  logic [W-1:0]  ac_q, ac_d;
  logic [W-1:0]  mq_q, mq_d;
  logic [CW-1:0] sc_q, sc_d;

  logic          idle;
  logic [CW:0]   shift_k;
  logic [1:0]    step_op;
  logic          step_l;
  logic [W-1:0]  step_ac, step_mq;
  logic          nxt_l;
  logic [W-1:0]  nxt_ac, nxt_mq;
  logic          norm_pre, norm_post;

  // In IDLE the step unit looks at the operands (normalisation check at start);
  // otherwise it advances the held registers.
  assign idle    = (state_q == ST_IDLE);
  assign step_op = idle ? op    : op_q;
  assign step_l  = idle ? l_in  : l_q;
  assign step_ac = idle ? ac_in : ac_q;
  assign step_mq = idle ? mq_in : mq_q;

  // Mode A shifts count+1 times, mode B exactly count times.
  assign shift_k = mode_b ? {1'b0, count} : ({1'b0, count} + (CW + 1)'(1));

  eae_shift_step #(.W(W)) u_step (
    .op          (step_op),
    .l_i         (step_l),
    .ac_i        (step_ac),
    .mq_i        (step_mq),
    .l_o         (nxt_l),
    .ac_o        (nxt_ac),
    .mq_o        (nxt_mq),
    .norm_o      (norm_pre),
    .norm_next_o (norm_post)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    l_d     = l_q;
    ac_d    = ac_q;
    mq_d    = mq_q;
    sc_d    = sc_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          op_d = op;
          l_d  = l_in;
          ac_d = ac_in;
          mq_d = mq_in;
          sc_d = '0;
          if ((op != EAE_NMI) && (shift_k > MAX_K)) begin
            state_d = ST_DONE;
            if (op == EAE_ASR) {l_d, ac_d, mq_d} = {(2 * W + 1){ac_in[W-1]}};
            else               {l_d, ac_d, mq_d} = '0;
          end else if ((op == EAE_NMI) ? norm_pre : (shift_k == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            if (op != EAE_NMI) sc_d = shift_k[CW-1:0];
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          {l_d, ac_d, mq_d} = {nxt_l, nxt_ac, nxt_mq};
          if (op_q == EAE_NMI) begin
            sc_d = sc_q + 1'b1;
            if (norm_post) state_d = ST_DONE;
          end else begin
            sc_d = sc_q - 1'b1;
            if (sc_q == CW'(1)) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      l_q     <= 1'b0;
      ac_q    <= '0;
      mq_q    <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      l_q     <= l_d;
      ac_q    <= ac_d;
      mq_q    <= mq_d;
      sc_q    <= sc_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE) && !abort;
  assign l_out  = l_q;
  assign ac_out = ac_q;
  assign mq_out = mq_q;
  assign sc_out = sc_q;

endmodule

// File: tb/tb_eae_shift_engine.sv
// Directed bench for eae_shift_engine (W=12, CW=5, octal data).
module tb_eae_shift_engine;
  import pdp8_eae_pkg::*;

  localparam int W  = 12;
  localparam int CW = 5;
  localparam int EW = 1 + 2 * W + CW;

  logic          clk, reset, start, abort, mode_b, l_in;
  logic [1:0]    op;
  logic [CW-1:0] count;
  logic [W-1:0]  ac_in, mq_in;
  logic          busy, done, l_out;
  logic [W-1:0]  ac_out, mq_out;
  logic [CW-1:0] sc_out;

  int n_tests;
  int n_fail;
  logic [EW-1:0] exp_q[$];

  eae_shift_engine #(.W(W), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .op     (op),
    .mode_b (mode_b),
    .count  (count),
    .l_in   (l_in),
    .ac_in  (ac_in),
    .mq_in  (mq_in),
    .busy   (busy),
    .done   (done),
    .l_out  (l_out),
    .ac_out (ac_out),
    .mq_out (mq_out),
    .sc_out (sc_out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic expect_res(input logic l, input logic [W-1:0] a, input logic [W-1:0] m,
                            input logic [CW-1:0] sc);
    exp_q.push_back({l, a, m, sc});
  endtask

  // Pulses start for one cycle; returns at the negedge after the accepting edge.
  task automatic launch(input logic [1:0] o, input logic mb, input logic [CW-1:0] c,
                        input logic l, input logic [W-1:0] a, input logic [W-1:0] m);
    @(negedge clk);
    op = o; mode_b = mb; count = c; l_in = l; ac_in = a; mq_in = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts edges after the accepting edge.
  task automatic wait_done(input string tag, input int lat0, input int exp_lat,
                           input int exp_busy);
    int lat;
    int bcnt;
    logic [EW-1:0] e;
    lat  = lat0;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bcnt, exp_busy);
    check({tag, "_expq"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_l"},  32'(l_out),  32'(e[EW-1]));
      check({tag, "_ac"}, 32'(ac_out), 32'(e[EW-2 -: W]));
      check({tag, "_mq"}, 32'(mq_out), 32'(e[CW+W-1 -: W]));
      check({tag, "_sc"}, 32'(sc_out), 32'(e[CW-1:0]));
      @(negedge clk);
      check({tag, "_done_once"}, 32'(done), 32'd0);
      check({tag, "_hold_ac"}, 32'(ac_out), 32'(e[EW-2 -: W]));
    end
  endtask

  task automatic run_case(input string tag, input logic [1:0] o, input logic mb,
                          input logic [CW-1:0] c, input logic l, input logic [W-1:0] a,
                          input logic [W-1:0] m, input logic el, input logic [W-1:0] ea,
                          input logic [W-1:0] em, input logic [CW-1:0] esc, input int lat);
    expect_res(el, ea, em, esc);
    launch(o, mb, c, l, a, m);
    wait_done(tag, 0, lat, lat);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; mode_b = 1'b0;
    count = '0; l_in = 1'b0; ac_in = '0; mq_in = '0;
    repeat (3) @(negedge clk);
    check("rst_l",    32'(l_out),  0);
    check("rst_ac",   32'(ac_out), 0);
    check("rst_mq",   32'(mq_out), 0);
    check("rst_sc",   32'(sc_out), 0);
    check("rst_busy", 32'(busy),   0);
    check("rst_done", 32'(done),   0);
    reset = 1'b0;

    //        tag        op       mb    cnt    l     ac        mq        el    eac       emq       esc    lat
    run_case("shl_a2",   EAE_SHL, 1'b0, 5'd2,  1'b0, 12'o0001, 12'o0000, 1'b0, 12'o0010, 12'o0000, 5'd0,  3);
    run_case("asr_b3",   EAE_ASR, 1'b1, 5'd3,  1'b0, 12'o4000, 12'o0000, 1'b1, 12'o7400, 12'o0000, 5'd0,  3);
    run_case("lsr_sat",  EAE_LSR, 1'b0, 5'd30, 1'b1, 12'o7777, 12'o7777, 1'b0, 12'o0000, 12'o0000, 5'd0,  0);
    run_case("asr_sat",  EAE_ASR, 1'b1, 5'd31, 1'b0, 12'o4000, 12'o0123, 1'b1, 12'o7777, 12'o7777, 5'd0,  0);
    run_case("shl_b26",  EAE_SHL, 1'b1, 5'd26, 1'b1, 12'o1234, 12'o4321, 1'b0, 12'o0000, 12'o0000, 5'd0,  0);
    run_case("shl_a24",  EAE_SHL, 1'b0, 5'd24, 1'b1, 12'o0000, 12'o0001, 1'b0, 12'o0000, 12'o0000, 5'd0,  25);
    run_case("shl_b24",  EAE_SHL, 1'b1, 5'd24, 1'b1, 12'o0000, 12'o0001, 1'b1, 12'o0000, 12'o0000, 5'd0,  24);
    run_case("shl_b0",   EAE_SHL, 1'b1, 5'd0,  1'b1, 12'o1234, 12'o5670, 1'b1, 12'o1234, 12'o5670, 5'd0,  0);
    run_case("lsr_a3",   EAE_LSR, 1'b0, 5'd3,  1'b1, 12'o7000, 12'o0017, 1'b0, 12'o0340, 12'o0000, 5'd0,  4);
    run_case("nmi_1",    EAE_NMI, 1'b0, 5'd7,  1'b0, 12'o0001, 12'o0000, 1'b0, 12'o2000, 12'o0000, 5'd10, 10);
    run_case("nmi_norm", EAE_NMI, 1'b0, 5'd5,  1'b0, 12'o2000, 12'o0000, 1'b0, 12'o2000, 12'o0000, 5'd0,  0);
    run_case("nmi_neg",  EAE_NMI, 1'b1, 5'd0,  1'b0, 12'o7777, 12'o4000, 1'b1, 12'o6000, 12'o0000, 5'd11, 11);
    run_case("nmi_zero", EAE_NMI, 1'b0, 5'd0,  1'b1, 12'o0000, 12'o0000, 1'b1, 12'o0000, 12'o0000, 5'd0,  0);

    // Abort in the fifth RUN cycle, with a competing start that must be dropped.
    launch(EAE_SHL, 1'b1, 5'd20, 1'b0, 12'o0001, 12'o0000);
    repeat (4) @(negedge clk);
    check("abort_busy_before", 32'(busy), 1);
    abort = 1'b1; start = 1'b1;
    op = EAE_LSR; ac_in = 12'o7777; mq_in = 12'o7777; l_in = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_busy", 32'(busy),   0);
    check("abort_done", 32'(done),   0);
    check("abort_ac",   32'(ac_out), 32'(12'o0020));
    check("abort_l",    32'(l_out),  0);
    check("abort_sc",   32'(sc_out), 16);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done | busy), 0);
    end
    check("abort_start_dropped", 32'(ac_out), 32'(12'o0020));
    run_case("after_abort", EAE_SHL, 1'b0, 5'd0, 1'b0, 12'o0001, 12'o0000,
             1'b0, 12'o0002, 12'o0000, 5'd0, 1);

    // Reset in the middle of an ASR.
    launch(EAE_ASR, 1'b0, 5'd10, 1'b1, 12'o4000, 12'o0017);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_l",    32'(l_out),  0);
    check("midrst_ac",   32'(ac_out), 0);
    check("midrst_mq",   32'(mq_out), 0);
    check("midrst_sc",   32'(sc_out), 0);
    check("midrst_busy", 32'(busy),   0);
    check("midrst_done", 32'(done),   0);

    // Start while busy is ignored; result is that of the first request.
    expect_res(1'b0, 12'o0020, 12'o0000, 5'd0);
    launch(EAE_SHL, 1'b1, 5'd4, 1'b0, 12'o0001, 12'o0000);
    op = EAE_LSR; mode_b = 1'b0; count = 5'd1; l_in = 1'b1;
    ac_in = 12'o7777; mq_in = 12'o7777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 1, 4, 3);

    check("expq_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
